// File: rtl/pmp_pkg.sv
// Shared PMP types and constants for the access arbiter and its neighbours.
package pmp_pkg;

  // One pmpcfg byte: lock, reserved, address-matching mode, X/W/R permissions.
  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    logic [1:0] a;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_t;

  localparam logic [1:0] OPER_R = 2'b00;
  localparam logic [1:0] OPER_W = 2'b01;
  localparam logic [1:0] OPER_X = 2'b10;

  localparam logic [1:0] PERM_NOMATCH = 2'b00;
  localparam logic [1:0] PERM_GRANT   = 2'b01;
  localparam logic [1:0] PERM_DENY    = 2'b10;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [3:0] CAUSE_NONE        = 4'd0;
  localparam logic [3:0] CAUSE_INSTR_FAULT = 4'd1;
  localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_LSU = 1'b0,
    OWN_IF  = 1'b1
  } owner_t;

  // Access-fault cause for a denied access; anything that is not a store
  // is reported as a load fault on the data side.
  function automatic logic [3:0] fault_cause(owner_t owner, logic [1:0] oper);
    if (owner == OWN_IF)
      return CAUSE_INSTR_FAULT;
    else if (oper == OPER_W)
      return CAUSE_STORE_FAULT;
    else
      return CAUSE_LOAD_FAULT;
  endfunction

endpackage

// File: rtl/pmp_access_arbiter_rr_arb2.sv
// Two-input round-robin grant. The grant is a function of the pointer
// register only, so ready never looks at the other port's valid.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_lsu,
  input  logic req_if,
  input  logic accept,
  output logic grant_lsu,
  output logic grant_if
);

  logic ptr_if;

  assign grant_if  = en & ptr_if;
  assign grant_lsu = en & ~ptr_if;

  // Pointer moves to the other side on accept; while idle it also hands the
  // grant over when only the non-favoured side is requesting.
  always_ff @(posedge clk) begin
    if (rst)
      ptr_if <= 1'b0;
    else if (accept)
      ptr_if <= ~ptr_if;
    else if (en && (ptr_if ? (!req_if && req_lsu) : (!req_lsu && req_if)))
      ptr_if <= ~ptr_if;
  end

endmodule

// File: rtl/pmp_access_arbiter.sv
// Time-shares one combinational PMP checker between fetch and load/store.
module pmp_access_arbiter
  import pmp_pkg::*;
#(
  parameter int unsigned XLEN            = 32,
  parameter bit          M_NOMATCH_ALLOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      priv_mode,
  input  logic            flush,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_rsp_valid,
  input  logic            if_rsp_ready,
  output logic            if_rsp_fault,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [2:0]      lsu_size,
  input  logic [1:0]      lsu_oper,
  output logic            lsu_rsp_valid,
  input  logic            lsu_rsp_ready,
  output logic            lsu_rsp_fault,
  output logic [3:0]      rsp_cause,
  output logic [XLEN-1:0] chk_addr,
  output logic [2:0]      chk_size,
  output logic [1:0]      chk_oper,
  output logic [1:0]      chk_prive_mode,
  input  logic [1:0]      chk_permission,
  output logic            busy
);

  arb_state_t      state_q, state_d;
  owner_t          owner_q;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      size_q;
  logic [1:0]      oper_q;
  logic [1:0]      priv_q;
  logic            fault_q;
  logic [3:0]      cause_q;

  logic idle, grant_lsu, grant_if;
  logic accept_if, accept_lsu, accept;
  logic if_kill, rsp_active;
  logic chk_ok;
  logic [3:0] chk_cause;

  // Readies are held low during reset so every output reads 0 there.
  assign idle = (state_q == ST_IDLE) && !rst;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .en        (idle),
    .req_lsu   (lsu_req_valid),
    .req_if    (if_req_valid & ~flush),
    .accept    (accept),
    .grant_lsu (grant_lsu),
    .grant_if  (grant_if)
  );

  assign lsu_req_ready = grant_lsu;
  assign if_req_ready  = grant_if & ~flush;
  assign accept_lsu    = lsu_req_valid & lsu_req_ready;
  assign accept_if     = if_req_valid & if_req_ready;
  assign accept        = accept_lsu | accept_if;
  assign if_kill       = (owner_q == OWN_IF) && flush;

  // Next-state: one cycle of checking, then hold the response until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_CHECK;
      ST_CHECK: state_d = if_kill ? ST_IDLE : ST_RESP;
      ST_RESP: begin
        if (if_kill)
          state_d = ST_IDLE;
        else if ((owner_q == OWN_IF) ? if_rsp_ready : lsu_rsp_ready)
          state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Permission decision from the checker result and the latched request.
  always_comb begin
    chk_ok = (chk_permission == PERM_GRANT) ||
             ((chk_permission == PERM_NOMATCH) && (priv_q == PRIV_M) && M_NOMATCH_ALLOW);
    if ((owner_q == OWN_LSU) && oper_q[1])
      chk_ok = 1'b0;
    chk_cause = chk_ok ? CAUSE_NONE : fault_cause(owner_q, oper_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Request latch on accept and result latch at the end of CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_LSU;
      addr_q  <= '0;
      size_q  <= '0;
      oper_q  <= '0;
      priv_q  <= '0;
      fault_q <= 1'b0;
      cause_q <= '0;
    end else begin
      if (accept) begin
        owner_q <= accept_if ? OWN_IF : OWN_LSU;
        addr_q  <= accept_if ? if_addr : lsu_addr;
        size_q  <= accept_if ? 3'd2 : lsu_size;
        oper_q  <= accept_if ? OPER_X : lsu_oper;
        priv_q  <= priv_mode;
      end
      if (state_q == ST_CHECK) begin
        fault_q <= ~chk_ok;
        cause_q <= chk_cause;
      end
    end
  end

  assign rsp_active     = (state_q == ST_RESP);
  assign if_rsp_valid   = rsp_active && (owner_q == OWN_IF);
  assign lsu_rsp_valid  = rsp_active && (owner_q == OWN_LSU);
  assign if_rsp_fault   = if_rsp_valid & fault_q;
  assign lsu_rsp_fault  = lsu_rsp_valid & fault_q;
  assign rsp_cause      = rsp_active ? cause_q : '0;
  assign chk_addr       = addr_q;
  assign chk_size       = size_q;
  assign chk_oper       = oper_q;
  assign chk_prive_mode = priv_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pmp_access_arbiter.sv
// Bench for pmp_access_arbiter: table of single transactions, directed
// corner sequences, then randomized traffic against a transaction model.
module tb_pmp_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  priv_mode;
  logic        flush;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_fault;
  logic [31:0] if_addr;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_fault;
  logic [31:0] lsu_addr;
  logic [2:0]  lsu_size;
  logic [1:0]  lsu_oper;
  logic [3:0]  rsp_cause;
  logic [31:0] chk_addr;
  logic [2:0]  chk_size;
  logic [1:0]  chk_oper, chk_prive_mode, chk_permission;
  logic        busy;

  logic        rand_mode;
  logic [1:0]  perm_drv;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Stand-in checker: fixed answer in directed tests, address-derived in random.
  assign chk_permission = rand_mode ? chk_addr[5:4] : perm_drv;

  pmp_access_arbiter #(.XLEN(32), .M_NOMATCH_ALLOW(1'b1)) dut (
    .clk(clk), .rst(rst), .priv_mode(priv_mode), .flush(flush),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_fault(if_rsp_fault),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_size(lsu_size), .lsu_oper(lsu_oper),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_fault(lsu_rsp_fault),
    .rsp_cause(rsp_cause), .chk_addr(chk_addr), .chk_size(chk_size), .chk_oper(chk_oper),
    .chk_prive_mode(chk_prive_mode), .chk_permission(chk_permission), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference rule: allowed on grant, or on no-match in M mode; LSU exec/reserved denied.
  function automatic logic [4:0] model(input bit is_if, input logic [1:0] oper,
                                       input logic [1:0] priv, input logic [1:0] perm);
    bit allowed;
    logic [3:0] cause;
    allowed = (perm == 2'b01) || (perm == 2'b00 && priv == 2'b11);
    if (!is_if && oper >= 2'b10) allowed = 0;
    if (allowed)     cause = 4'd0;
    else if (is_if)  cause = 4'd1;
    else if (oper == 2'b01) cause = 4'd7;
    else             cause = 4'd5;
    return {!allowed, cause};
  endfunction

  // Presents one request and returns at the negedge of the cycle after accept.
  task automatic issue(input bit is_if, input logic [31:0] addr, input logic [2:0] size,
                       input logic [1:0] oper, input logic [1:0] priv, input logic [1:0] perm);
    int n;
    @(negedge clk);
    perm_drv  = perm;
    priv_mode = priv;
    if (is_if) begin
      if_addr = addr; if_req_valid = 1'b1;
    end else begin
      lsu_addr = addr; lsu_size = size; lsu_oper = oper; lsu_req_valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(is_if ? if_req_ready : lsu_req_ready) && n < 8) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_within_bound", {31'd0, (is_if ? if_req_ready : lsu_req_ready)}, 32'd1);
    @(negedge clk);
    if_req_valid  = 1'b0;
    lsu_req_valid = 1'b0;
    #1;
  endtask

  typedef struct {
    bit          is_if;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  oper;
    logic [1:0]  priv;
    logic [1:0]  perm;
    bit          fault;
    logic [3:0]  cause;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int grants[$];
    int n;
    bit seen;
    bit if_pend, lsu_pend, have_exp, exp_if, last_grant, last_known, both_prev, both_now;
    logic [4:0] exp;
    int cyc, acc_cyc, if_wait, lsu_wait;
    int unsigned pm;

    tbl[0] = '{0, 32'h8000_0010, 3'd2, 2'b00, 2'b00, 2'b01, 0, 4'd0};
    tbl[1] = '{1, 32'h0000_1000, 3'd2, 2'b10, 2'b01, 2'b00, 1, 4'd1};
    tbl[2] = '{1, 32'h0000_1004, 3'd2, 2'b10, 2'b11, 2'b00, 0, 4'd0};
    tbl[3] = '{0, 32'h0000_2002, 3'd1, 2'b01, 2'b00, 2'b10, 1, 4'd7};
    tbl[4] = '{0, 32'h0000_2100, 3'd0, 2'b00, 2'b11, 2'b00, 0, 4'd0};
    tbl[5] = '{0, 32'h0000_2104, 3'd2, 2'b00, 2'b01, 2'b00, 1, 4'd5};
    tbl[6] = '{0, 32'h0000_2108, 3'd2, 2'b10, 2'b11, 2'b01, 1, 4'd5};
    tbl[7] = '{0, 32'h0000_210c, 3'd2, 2'b01, 2'b11, 2'b11, 1, 4'd7};
    tbl[8] = '{1, 32'h0000_3000, 3'd2, 2'b10, 2'b11, 2'b10, 1, 4'd1};
    tbl[9] = '{1, 32'h0000_3004, 3'd2, 2'b10, 2'b00, 2'b01, 0, 4'd0};

    rst = 1'b1; flush = 1'b0; priv_mode = 2'b00; rand_mode = 1'b0; perm_drv = 2'b01;
    if_req_valid = 0; if_addr = '0; if_rsp_ready = 0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_size = '0; lsu_oper = '0; lsu_rsp_ready = 0;

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {30'd0, if_req_ready, lsu_req_ready}, 32'd0);
    chk("rst_rsp", {28'd0, if_rsp_valid, lsu_rsp_valid, if_rsp_fault, lsu_rsp_fault}, 32'd0);
    chk("rst_busy_cause", {27'd0, busy, rsp_cause}, 32'd0);
    chk("rst_chk", chk_addr | {27'd0, chk_size, chk_oper} | {30'd0, chk_prive_mode}, 32'd0);
    rst = 1'b0;

    // Contention straight after reset: LSU first, then alternating.
    @(negedge clk);
    if_addr = 32'h100; lsu_addr = 32'h200; lsu_size = 3'd2; lsu_oper = 2'b00;
    if_req_valid = 1; lsu_req_valid = 1; if_rsp_ready = 1; lsu_rsp_ready = 1;
    n = 0;
    while (grants.size() < 4 && n < 30) begin
      #1;
      if (lsu_req_valid && lsu_req_ready) grants.push_back(0);
      if (if_req_valid && if_req_ready)   grants.push_back(1);
      @(negedge clk); n++;
    end
    if_req_valid = 0; lsu_req_valid = 0;
    chk("contend_count", grants.size(), 32'd4);
    for (int i = 0; i < grants.size(); i++)
      chk($sformatf("contend_grant%0d", i), grants[i], (i % 2 == 0) ? 32'd0 : 32'd1);
    repeat (4) @(negedge clk);
    if_rsp_ready = 0; lsu_rsp_ready = 0;

    // Table of single transactions.
    for (int unsigned i = 0; i < 10; i++) begin
      issue(tbl[i].is_if, tbl[i].addr, tbl[i].size, tbl[i].oper, tbl[i].priv, tbl[i].perm);
      chk($sformatf("v%0d_check_busy", i), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_check_norsp", i), {30'd0, if_rsp_valid, lsu_rsp_valid}, 32'd0);
      chk($sformatf("v%0d_chk_addr", i), chk_addr, tbl[i].addr);
      chk($sformatf("v%0d_chk_size", i), {29'd0, chk_size}, tbl[i].is_if ? 32'd2 : {29'd0, tbl[i].size});
      chk($sformatf("v%0d_chk_oper", i), {30'd0, chk_oper}, tbl[i].is_if ? 32'd2 : {30'd0, tbl[i].oper});
      chk($sformatf("v%0d_chk_priv", i), {30'd0, chk_prive_mode}, {30'd0, tbl[i].priv});
      @(negedge clk); #1;
      chk($sformatf("v%0d_rsp_valid", i), {30'd0, if_rsp_valid, lsu_rsp_valid},
          tbl[i].is_if ? 32'd2 : 32'd1);
      chk($sformatf("v%0d_fault", i), {31'd0, (if_rsp_fault | lsu_rsp_fault)}, {31'd0, tbl[i].fault});
      chk($sformatf("v%0d_cause", i), {28'd0, rsp_cause}, {28'd0, tbl[i].cause});
      if_rsp_ready = 1; lsu_rsp_ready = 1;
      @(negedge clk);
      if_rsp_ready = 0; lsu_rsp_ready = 0;
      #1;
      chk($sformatf("v%0d_done_idle", i), {31'd0, busy}, 32'd0);
    end

    // Back-pressure: denied store held for 5 cycles.
    issue(0, 32'h0000_4000, 3'd2, 2'b01, 2'b00, 2'b10);
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("bp%0d_hold", k), {26'd0, lsu_rsp_valid, lsu_rsp_fault, busy, rsp_cause[2:0]},
          {26'd0, 1'b1, 1'b1, 1'b1, 3'd7});
    end
    lsu_rsp_ready = 1;
    @(negedge clk); lsu_rsp_ready = 0; #1;
    chk("bp_release", {30'd0, busy, lsu_rsp_valid}, 32'd0);

    // Flush during IF response.
    issue(1, 32'h0000_5000, 3'd2, 2'b10, 2'b11, 2'b01);
    @(negedge clk); #1;
    chk("flush_resp_pre", {31'd0, if_rsp_valid}, 32'd1);
    flush = 1;
    @(negedge clk); flush = 0; #1;
    chk("flush_resp_drop", {30'd0, if_rsp_valid, busy}, 32'd0);

    // Flush during IF check.
    issue(1, 32'h0000_5004, 3'd2, 2'b10, 2'b11, 2'b01);
    flush = 1;
    @(negedge clk); flush = 0; #1;
    chk("flush_check_drop", {30'd0, if_rsp_valid, busy}, 32'd0);
    @(negedge clk); #1;
    chk("flush_check_stays", {30'd0, if_rsp_valid, busy}, 32'd0);

    // No IF accept while flush is high.
    @(negedge clk);
    flush = 1; if_req_valid = 1; if_addr = 32'h6000;
    for (int unsigned k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("flush_block%0d", k), {30'd0, if_req_ready, busy}, 32'd0);
      @(negedge clk);
    end
    flush = 0; if_req_valid = 0;

    // LSU ignores flush.
    issue(0, 32'h0000_7000, 3'd2, 2'b00, 2'b00, 2'b01);
    flush = 1;
    @(negedge clk); #1;
    chk("flush_lsu_kept", {30'd0, lsu_rsp_valid, busy}, 32'd3);
    flush = 0; lsu_rsp_ready = 1;
    @(negedge clk); lsu_rsp_ready = 0;

    // Flush together with if_rsp_ready: dropped, pointer still moved past IF.
    issue(1, 32'h0000_8000, 3'd2, 2'b10, 2'b11, 2'b01);
    @(negedge clk);
    flush = 1; if_rsp_ready = 1;
    @(negedge clk); flush = 0; if_rsp_ready = 0; #1;
    chk("flush_ready_idle", {31'd0, busy}, 32'd0);
    if_req_valid = 1; lsu_req_valid = 1; #1;
    chk("flush_ready_ptr", {30'd0, if_req_ready, lsu_req_ready}, 32'd1);
    if_req_valid = 0; lsu_req_valid = 0;

    // Reset during CHECK aborts the transaction.
    issue(0, 32'h0000_9000, 3'd2, 2'b00, 2'b00, 2'b01);
    rst = 1;
    @(negedge clk); #1;
    chk("rst_mid_outputs", {26'd0, if_req_ready, lsu_req_ready, if_rsp_valid, lsu_rsp_valid, busy,
                            (|rsp_cause)}, 32'd0);
    chk("rst_mid_chk_addr", chk_addr, 32'd0);
    rst = 0; lsu_rsp_ready = 1;
    seen = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (lsu_rsp_valid) seen = 1;
    end
    chk("rst_mid_no_rsp", {31'd0, seen}, 32'd0);
    lsu_rsp_ready = 0;

    // Randomized traffic against the transaction model.
    rand_mode = 1;
    if_pend = 0; lsu_pend = 0; have_exp = 0; last_known = 0; both_prev = 0;
    last_grant = 0; exp_if = 0; exp = '0; acc_cyc = 0; if_wait = 0; lsu_wait = 0;
    for (cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (!if_pend) begin
        if_req_valid = ($urandom_range(0, 2) == 0);
        if_addr = $urandom;
      end
      if (!lsu_pend) begin
        lsu_req_valid = ($urandom_range(0, 2) == 0);
        lsu_addr = $urandom;
        lsu_size = 3'($urandom_range(0, 2));
        lsu_oper = 2'($urandom_range(0, 3));
      end
      if_pend = if_req_valid; lsu_pend = lsu_req_valid;
      pm = $urandom_range(0, 2);
      priv_mode = (pm == 2) ? 2'b11 : 2'(pm);
      if_rsp_ready  = ($urandom_range(0, 3) != 0);
      lsu_rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      both_now = if_req_valid && lsu_req_valid;

      if (have_exp && cyc == acc_cyc + 2)
        chk("rnd_latency", {31'd0, (exp_if ? if_rsp_valid : lsu_rsp_valid)}, 32'd1);
      if (have_exp && (if_rsp_valid || lsu_rsp_valid)) begin
        chk("rnd_rsp_port", {30'd0, if_rsp_valid, lsu_rsp_valid}, exp_if ? 32'd2 : 32'd1);
        chk("rnd_rsp_fault", {31'd0, (if_rsp_fault | lsu_rsp_fault)}, {31'd0, exp[4]});
        chk("rnd_rsp_cause", {28'd0, rsp_cause}, {28'd0, exp[3:0]});
        if ((exp_if && if_rsp_ready) || (!exp_if && lsu_rsp_ready)) have_exp = 0;
      end else if (!have_exp) begin
        chk("rnd_no_spurious_rsp", {30'd0, if_rsp_valid, lsu_rsp_valid}, 32'd0);
      end
      if (have_exp && cyc > acc_cyc + 40) begin
        chk("rnd_rsp_timeout", 32'd1, 32'd0);
        have_exp = 0;
      end

      if (if_req_ready && lsu_req_ready) chk("rnd_ready_onehot", 32'd1, 32'd0);
      if ((if_req_valid && if_req_ready) || (lsu_req_valid && lsu_req_ready)) begin
        exp_if = if_req_valid && if_req_ready;
        chk("rnd_accept_when_free", {31'd0, have_exp}, 32'd0);
        if (last_known && both_now && both_prev)
          chk("rnd_rr_fair", {31'd0, exp_if}, {31'd0, !last_grant});
        last_grant = exp_if; last_known = 1;
        if (exp_if) exp = model(1, 2'b10, priv_mode, if_addr[5:4]);
        else        exp = model(0, lsu_oper, priv_mode, lsu_addr[5:4]);
        have_exp = 1; acc_cyc = cyc;
        if (exp_if) if_pend = 0; else lsu_pend = 0;
      end
      if_wait  = if_pend  ? if_wait + 1  : 0;
      lsu_wait = lsu_pend ? lsu_wait + 1 : 0;
      if (if_wait > 30 || lsu_wait > 30) begin
        chk("rnd_req_starved", 32'd1, 32'd0);
        if_wait = 0; lsu_wait = 0;
      end
      both_prev = both_now;
    end
    if_req_valid = 0; lsu_req_valid = 0;
    if_rsp_ready = 1; lsu_rsp_ready = 1;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pmp_access_arbiter.md
# pmp_access_arbiter

Sequencer that shares the single combinational PMP checker (16 entries, pmpcfg0–3 / pmpaddr0–15) between the instruction-fetch and load/store units. It accepts one request at a time over valid/ready, drives the checker's address/size/operation/privilege inputs for one cycle, and registers the permission result. It applies the no-match privilege rule and returns a per-requester response with a fault flag and RISC-V exception cause.

## Interface
- `XLEN`, 32: address width; must match the checker.
- `M_NOMATCH_ALLOW`, 1: when 1, an M-mode access matching no entry is allowed.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `priv_mode` in 2: current privilege (00 U, 01 S, 11 M); sampled at accept.
- `flush` in 1: pipeline flush; kills an in-flight IF transaction.
- `if_req_valid` in 1 / `if_req_ready` out 1 / `if_addr` in XLEN: fetch request.
- `if_rsp_valid` out 1 / `if_rsp_ready` in 1 / `if_rsp_fault` out 1: fetch response.
- `lsu_req_valid` in 1 / `lsu_req_ready` out 1 / `lsu_addr` in XLEN / `lsu_size` in 3 / `lsu_oper` in 2: data request (size 0 byte, 1 half, 2 word; oper 00 R, 01 W).
- `lsu_rsp_valid` out 1 / `lsu_rsp_ready` in 1 / `lsu_rsp_fault` out 1: data response.
- `rsp_cause` out 4: exception cause, valid with either rsp_valid.
- `chk_addr` out XLEN / `chk_size` out 3 / `chk_oper` out 2 / `chk_prive_mode` out 2: checker inputs.
- `chk_permission` in 2: checker result (01 granted, 10 denied, 00 no match, 11 treated as denied).
- `busy` out 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, CHECK, RESP.
- IDLE: `if_req_ready`/`lsu_req_ready` high only for the granted requester. On a valid request, latch addr, size, oper, priv, and the owner ID; go to CHECK.
- Arbitration is round-robin. On a simultaneous request, grant the requester not granted last. After reset, LSU has priority.
- IF requests are forced to size 2 and oper 10 (X).
- CHECK: drive the latched fields on the `chk_*` outputs and sample `chk_permission`.
  - Allowed if the result is 01.
  - Allowed if the result is 00, priv is M, and `M_NOMATCH_ALLOW`=1.
  - Otherwise denied.
  - An LSU oper of 10 or 11 is always denied.
  - Go to RESP.
- RESP: hold the owner's `rsp_valid`, fault, and `rsp_cause` until its `rsp_ready` is high; then go to IDLE.
- Cause on fault: IF → 1, LSU read → 5, LSU write → 7. Cause is 0 when there is no fault.
- `chk_*` outputs hold the latched values outside CHECK; they are 0 after reset.
- Flush:
  - If `flush` is high while the owner is IF in CHECK or RESP, the transaction is dropped: go to IDLE, and `if_rsp_valid` is low from the next cycle.
  - While `flush` is high, no IF request is accepted in IDLE.
  - LSU transactions ignore `flush`.

## Timing
- Reset values: all ready, rsp_valid, fault, `rsp_cause`, `busy`, and `chk_*` outputs are 0; state is IDLE; the round-robin pointer gives LSU priority.
- Reset mid-transaction aborts it; no response is produced.
- Latency: request accepted at edge N; checker driven in cycle N+1; `rsp_valid` high from edge N+2.
- Throughput: one transaction per 3 cycles minimum.
- Ready is combinational from state and the arbiter only. It never depends on the same cycle's `req_valid` of the other port.
- A requester must hold req fields stable while valid and not ready.
- A response held by back-pressure keeps all its fields stable.
- `rsp_ready` asserted with `rsp_valid` low is ignored.
- `flush` and `if_rsp_ready` in the same RESP cycle: the response counts as dropped. The round-robin pointer still updates, since the grant occurred.

## Structure
- Shared package `pmp_pkg`:
  - `pmpcfg` typedef (L, A, X, W, R fields).
  - Oper constants: R=00, W=01, X=10.
  - Permission codes: 00, 01, 10.
  - Privilege constants: U, S, M.
  - Cause constants: 1, 5, 7.
  - FSM state enum.
- One sub-module, `rr_arb2`: two-input round-robin grant with a pointer register, updated on accept.
- The checker is instantiated beside this block at the next level up, not inside it.

## Test plan
- LSU read 0x8000_0010, priv U, checker returns 01 → lsu_rsp_valid at N+2, fault 0, cause 0.
- IF fetch, priv S, checker returns 00 → if_rsp_fault 1, cause 1; same with priv M → fault 0.
- Simultaneous IF and LSU requests after reset → LSU granted first, IF accepted on the next IDLE. Repeated contention alternates grants.
- LSU write with checker 10, lsu_rsp_ready low for 5 cycles → response held stable, fault 1, cause 7, busy 1 throughout.
- IF in RESP with flush pulsed → if_rsp_valid 0 next cycle, state IDLE. An IF request during flush is not accepted.
- rst asserted in CHECK → next cycle all outputs 0 and no response is ever delivered.
